// File: rtl/pd_axis_sched_if.sv
// pd_axis_sched_if: sample/term bus of the PD scheduler; drop_cnt exists only with PD_DROP_CNT_EN.
interface pd_axis_sched_if;
  logic vld;
  logic signed [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
  logic busy, done;
  logic signed [9:0] ptch_pterm, roll_pterm, yaw_pterm;
  logic signed [11:0] ptch_dterm, roll_dterm, yaw_dterm;
`ifdef PD_DROP_CNT_EN
  logic [7:0] drop_cnt;
  modport master (output vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
                  input busy, done, ptch_pterm, roll_pterm, yaw_pterm,
                  ptch_dterm, roll_dterm, yaw_dterm, drop_cnt);
  modport slave (input vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
                 output busy, done, ptch_pterm, roll_pterm, yaw_pterm,
                 ptch_dterm, roll_dterm, yaw_dterm, drop_cnt);
`else
  modport master (output vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
                  input busy, done, ptch_pterm, roll_pterm, yaw_pterm,
                  ptch_dterm, roll_dterm, yaw_dterm);
  modport slave (input vld, d_ptch, d_roll, d_yaw, ptch, roll, yaw,
                 output busy, done, ptch_pterm, roll_pterm, yaw_pterm,
                 ptch_dterm, roll_dterm, yaw_dterm);
`endif
endinterface

// File: rtl/pd_axis_sched.sv
// pd_axis_sched: one shared PD datapath sequenced over pitch/roll/yaw with a circular D history.
// Optional PD_DROP_CNT_EN adds a saturating count of vld pulses ignored while busy.
module pd_axis_sched #(
  parameter int D_QUEUE_DEPTH = 14,
  parameter logic signed [5:0] D_COEFF = 6'sd7
) (
  input logic clk,
  input logic rst,
  pd_axis_sched_if.slave bus
);
  localparam int PW = $clog2(D_QUEUE_DEPTH);
  localparam int HN = 3 * D_QUEUE_DEPTH;
  localparam int IW = $clog2(HN);
  typedef enum logic [1:0] {IDLE, AX_ERR, AX_TERM, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0] r_axis;
  logic [PW-1:0] r_wr_ptr;
  logic signed [15:0] r_des [3];
  logic signed [15:0] r_meas [3];
  logic signed [9:0] r_err, r_hrd;
  logic signed [9:0] r_hist [HN];
  logic signed [9:0] r_pt [3];
  logic signed [9:0] r_opt [3];
  logic signed [11:0] r_dt [3];
  logic signed [11:0] r_odt [3];
  logic r_busy, r_done;
  logic signed [16:0] w_err17;
  logic signed [9:0] w_err_sat, w_pterm;
  logic signed [10:0] w_diff;
  logic signed [5:0] w_diff_sat;
  logic signed [11:0] w_dterm;
  logic [IW-1:0] w_idx;
  assign w_err17 = 17'(r_meas[r_axis]) - 17'(r_des[r_axis]);
  assign w_err_sat = w_err17 > 17'sd511 ? 10'sd511 :
                     w_err17 < -17'sd512 ? -10'sd512 : w_err17[9:0];
  assign w_pterm = (r_err >>> 1) + (r_err >>> 3);
  assign w_diff = 11'(r_err) - 11'(r_hrd);
  assign w_diff_sat = w_diff > 11'sd31 ? 6'sd31 :
                      w_diff < -11'sd32 ? -6'sd32 : w_diff[5:0];
  assign w_dterm = 12'(w_diff_sat) * 12'(D_COEFF);
  assign w_idx = IW'(r_axis) * IW'(D_QUEUE_DEPTH) + IW'(r_wr_ptr);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.vld ? AX_ERR : IDLE;
      AX_ERR:  w_next = AX_TERM;
      AX_TERM: w_next = r_axis == 2'd2 ? DONE : AX_ERR;
      default: w_next = IDLE;
    endcase
  end
  // history slot is read in AX_ERR and overwritten in AX_TERM, so each axis sees its own oldest sample
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_axis <= '0;
      r_wr_ptr <= '0;
      r_err <= '0;
      r_hrd <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_des[i] <= '0;
        r_meas[i] <= '0;
        r_pt[i] <= '0;
        r_dt[i] <= '0;
        r_opt[i] <= '0;
        r_odt[i] <= '0;
      end
      for (int i = 0; i < HN; i++) r_hist[i] <= '0;
    end else begin
      r_busy <= r_state != IDLE;
      r_done <= r_state == DONE;
      if (r_state == IDLE && bus.vld) begin
        r_axis <= '0;
        r_des[0] <= bus.d_ptch;
        r_des[1] <= bus.d_roll;
        r_des[2] <= bus.d_yaw;
        r_meas[0] <= bus.ptch;
        r_meas[1] <= bus.roll;
        r_meas[2] <= bus.yaw;
      end
      if (r_state == AX_ERR) begin
        r_err <= w_err_sat;
        r_hrd <= r_hist[w_idx];
      end
      if (r_state == AX_TERM) begin
        r_hist[w_idx] <= r_err;
        r_pt[r_axis] <= w_pterm;
        r_dt[r_axis] <= w_dterm;
        r_axis <= r_axis + 2'd1;
      end
      if (r_state == DONE) begin
        r_opt <= r_pt;
        r_odt <= r_dt;
        r_wr_ptr <= r_wr_ptr == PW'(D_QUEUE_DEPTH - 1) ? '0 : r_wr_ptr + PW'(1);
      end
    end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ptch_pterm = r_opt[0];
  assign bus.roll_pterm = r_opt[1];
  assign bus.yaw_pterm = r_opt[2];
  assign bus.ptch_dterm = r_odt[0];
  assign bus.roll_dterm = r_odt[1];
  assign bus.yaw_dterm = r_odt[2];
`ifdef PD_DROP_CNT_EN
  logic [7:0] r_drop;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_drop <= '0;
    else if (bus.vld && r_state != IDLE && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
  assign bus.drop_cnt = r_drop;
`endif
endmodule

// File: tb/tb_pd_axis_sched.sv
// tb_pd_axis_sched: directed-vector bench for pd_axis_sched; drop-count checks need PD_DROP_CNT_EN.
module tb_pd_axis_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  pd_axis_sched_if bus ();
  pd_axis_sched dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    bus.vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic set_in(input logic signed [15:0] dp, dr, dy, p, r, y);
    bus.d_ptch = dp;
    bus.d_roll = dr;
    bus.d_yaw = dy;
    bus.ptch = p;
    bus.roll = r;
    bus.yaw = y;
  endtask
  task automatic run(input logic signed [15:0] dp, dr, dy, p, r, y);
    int lat;
    set_in(dp, dr, dy, p, r, y);
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    check("busy_edge0", bus.busy, 0);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 7);
    check("busy_done", bus.busy, 1);
    @(negedge clk);
    check("done_1cyc", bus.done, 0);
    check("busy_end", bus.busy, 0);
  endtask
  task automatic count_done(input int cycles, output int dn);
    dn = 0;
    repeat (cycles) begin
      if (bus.done === 1'b1) dn++;
      @(negedge clk);
    end
  endtask
  initial begin
    int dn;
    bus.vld = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    do_reset();
    check("rst_ptch_pt", bus.ptch_pterm, 0);
    check("rst_roll_pt", bus.roll_pterm, 0);
    check("rst_yaw_pt", bus.yaw_pterm, 0);
    check("rst_ptch_dt", bus.ptch_dterm, 0);
    check("rst_roll_dt", bus.roll_dterm, 0);
    check("rst_yaw_dt", bus.yaw_dterm, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    count_done(10, dn);
    check("no_done_idle", dn, 0);
`ifdef PD_DROP_CNT_EN
    check("rst_drop", bus.drop_cnt, 0);
`endif
    run(0, 0, 0, 100, 0, 0);
    check("p100_pt", bus.ptch_pterm, 62);
    check("p100_dt", bus.ptch_dterm, 217);
    check("p100_roll_pt", bus.roll_pterm, 0);
    check("p100_roll_dt", bus.roll_dterm, 0);
    check("p100_yaw_pt", bus.yaw_pterm, 0);
    check("p100_yaw_dt", bus.yaw_dterm, 0);
    do_reset();
    run(16'sh8000, 0, 0, 16'sh7FFF, 0, 0);
    check("satpos_pt", bus.ptch_pterm, 318);
    check("satpos_dt", bus.ptch_dterm, 217);
    do_reset();
    run(0, 0, 0, -16'sd1000, 0, 0);
    check("satneg_pt", bus.ptch_pterm, -320);
    check("satneg_dt", bus.ptch_dterm, -224);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run(0, 5, 0, 0, 25, 0);
      check($sformatf("roll_pt_%0d", i), bus.roll_pterm, 12);
      check($sformatf("roll_dt_%0d", i), bus.roll_dterm, i < 14 ? 140 : 0);
      check($sformatf("roll_ptch_%0d", i), bus.ptch_dterm, 0);
    end
    do_reset();
    set_in(0, 0, 0, 100, 0, 0);
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    count_done(20, dn);
    check("drop_single_done", dn, 1);
    check("drop_pt", bus.ptch_pterm, 62);
`ifdef PD_DROP_CNT_EN
    check("drop_cnt_1", bus.drop_cnt, 1);
    bus.vld = 1'b1;
    repeat (350) @(negedge clk);
    bus.vld = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_cnt_sat", bus.drop_cnt, 255);
`endif
    do_reset();
    run(0, 0, 0, 100, 0, 0);
    check("pre_abort_pt", bus.ptch_pterm, 62);
    bus.vld = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pt", bus.ptch_pterm, 0);
    check("abort_dt", bus.ptch_dterm, 0);
    check("abort_busy", bus.busy, 0);
    count_done(12, dn);
    check("abort_no_done", dn, 0);
    run(0, 0, 0, 100, 0, 0);
    check("post_abort_dt", bus.ptch_dterm, 217);
    check("post_abort_pt", bus.ptch_pterm, 62);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
